// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder: WIDTH-bit add split into SEG_WIDTH-bit stages with registered carries,
// skewed operands and a deskewed sum. Optional subtract port via `PIPELINED_SEGMENT_ADDER_ADDSUB_EN.
module pipelined_segment_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_SEGMENT_ADDER_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int NSEG = WIDTH / SEG_WIDTH;

    if (WIDTH % SEG_WIDTH != 0) begin : g_bad_width
        $error("pipelined_segment_adder: WIDTH must be a multiple of SEG_WIDTH");
    end

    logic             stall_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic             last_vld_s;
    logic             last_cry_s;
    logic [WIDTH-1:0] last_acc_s;

    // Global stall: a held result freezes every stage and blocks new input.
    always_comb begin
        stall_s  = out_valid & ~out_ready;
        in_ready = ~stall_s;
    end

    // Operand conditioning; a subtract enters the pipeline as a + ~b + 1.
    always_comb begin
        b_eff_s   = b;
        cin_eff_s = cin;
`ifdef PIPELINED_SEGMENT_ADDER_ADDSUB_EN
        if (sub) begin
            b_eff_s   = ~b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b;
            cin_eff_s = cin;
        end
`endif
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        // IW: operand bits not yet consumed on entry to this stage; AW: sum bits produced so far.
        localparam int IW = WIDTH - SEG_WIDTH * k;
        localparam int AW = SEG_WIDTH * (k + 1);

        logic [IW-1:0]      ina_s;
        logic [IW-1:0]      inb_s;
        logic               cin_s;
        logic               vin_s;
        logic [SEG_WIDTH:0] add_s;
        logic [AW-1:0]      acc_s;
        logic [AW-1:0]      acc_r;
        logic               cry_r;
        logic               vld_r;

        if (k == 0) begin : g_head
            assign ina_s = a;
            assign inb_s = b_eff_s;
            assign cin_s = cin_eff_s;
            assign vin_s = in_valid;
            assign acc_s = add_s[SEG_WIDTH-1:0];
        end else begin : g_body
            assign ina_s = g_seg[k-1].g_rem.opa_r;
            assign inb_s = g_seg[k-1].g_rem.opb_r;
            assign cin_s = g_seg[k-1].cry_r;
            assign vin_s = g_seg[k-1].vld_r;
            assign acc_s = {add_s[SEG_WIDTH-1:0], g_seg[k-1].acc_r};
        end

        assign add_s = {1'b0, ina_s[SEG_WIDTH-1:0]} + {1'b0, inb_s[SEG_WIDTH-1:0]}
                     + {{SEG_WIDTH{1'b0}}, cin_s};

        // Stage register: slot valid, carry out of this segment, low sum bits accumulated so far.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_r <= 1'b0;
                cry_r <= 1'b0;
                acc_r <= '0;
            end else if (!stall_s) begin
                vld_r <= vin_s;
                cry_r <= add_s[SEG_WIDTH];
                acc_r <= acc_s;
            end
        end

        if (IW > SEG_WIDTH) begin : g_rem
            logic [IW-SEG_WIDTH-1:0] opa_r;
            logic [IW-SEG_WIDTH-1:0] opb_r;

            // Skew register: unconsumed upper segments ride one stage further.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    opa_r <= '0;
                    opb_r <= '0;
                end else if (!stall_s) begin
                    opa_r <= ina_s[IW-1:SEG_WIDTH];
                    opb_r <= inb_s[IW-1:SEG_WIDTH];
                end
            end
        end

        if (k == NSEG - 1) begin : g_tail
            assign last_vld_s = vld_r;
            assign last_cry_s = cry_r;
            assign last_acc_s = acc_r;
        end
    end

    // Output register: capture a valid slot, keep the last result across bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
        end else if (!stall_s) begin
            out_valid <= last_vld_s;
            if (last_vld_s) begin
                sum   <= last_acc_s;
                carry <= last_cry_s;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder: directed cases plus random traffic with back-pressure.
module tb_pipelined_segment_adder;
    localparam int WIDTH     = 32;
    localparam int SEG_WIDTH = 8;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef PIPELINED_SEGMENT_ADDER_ADDSUB_EN
    logic             sub       = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] exp_q[$];
    logic           mon_en     = 1'b0;
    logic [WIDTH:0] last_seen  = '0;
    logic [WIDTH:0] stall_val  = '0;
    logic           stall_prev = 1'b0;
    logic [WIDTH:0] mon_e;

    always #5 clock = ~clock;

    pipelined_segment_adder #(.WIDTH(WIDTH), .SEG_WIDTH(SEG_WIDTH)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_SEGMENT_ADDER_ADDSUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry)
    );

    // Reference: {carry, sum} from plain unsigned arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
        logic [WIDTH:0] r;
        if (s) begin
            r[WIDTH-1:0] = x - y;
            r[WIDTH]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b1, {(WIDTH-1){1'b0}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expectation is queued if the DUT takes the operation.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s, input logic ordy);
        logic sb;
        @(negedge clock);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = ci;
        out_ready = ordy;
        sb        = 1'b0;
`ifdef PIPELINED_SEGMENT_ADDER_ADDSUB_EN
        sub = s;
        sb  = s;
`endif
        #4;
        if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sb));
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            idle(1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
        end
    endtask

    // Monitor: pops and compares on every output transfer, checks stall and bubble rules.
    initial forever begin
        @(negedge clock);
        #4;
        if (mon_en && reset_n) begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_hold", {carry, sum}, stall_val);
            end
            if (out_valid) begin
                last_seen = {carry, sum};
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got sum=0x%0h carry=%0b, expected no result", sum, carry);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sum", sum, mon_e[WIDTH-1:0]);
                        check("carry", carry, mon_e[WIDTH]);
                    end
                end
            end else begin
                check("bubble_hold", {carry, sum}, last_seen);
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {carry, sum};
        end
    end

    initial begin
        int stalls;
        int run;
        int maxrun;
        int nvalid;

        @(negedge clock);
        #4;
        check("reset_valid", out_valid, 1'b0);
        check("reset_sum", sum, '0);
        check("reset_carry", carry, 1'b0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Latency: valid appears exactly NSEG edges after acceptance.
        cycle(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("latency_early", out_valid, 1'b0);
        end
        idle(1'b1);
        check("latency_valid", out_valid, 1'b1);
        check("latency_sum", sum, 32'h0000_0100);
        drain();

        // Full ripple through every stage.
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back: four results on four consecutive cycles.
        run = 0; maxrun = 0; nvalid = 0;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0:       cycle(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
                1:       cycle(1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
                2:       cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
                3:       cycle(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
                default: idle(1'b1);
            endcase
            if (out_valid) begin
                nvalid++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("b2b_count", nvalid, 4);
        check("b2b_consecutive", maxrun, 4);

        // Back-pressure: output held while pipeline fills, then released.
        stalls = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, rand_op(), rand_op(), 1'(i % 2), 1'b0, 1'b0);
            if (!in_ready) stalls++;
        end
        check("stall_cycles", (stalls >= 3), 1'b1);
        drain();

        // Random traffic with random back-pressure and bubbles.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        drain();

`ifdef PIPELINED_SEGMENT_ADDER_ADDSUB_EN
        cycle(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
        drain();
`endif

        // Asynchronous reset with operations in flight.
        cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        check("pre_reset_valid", out_valid, 1'b1);
        #3;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 1'b0);
        check("async_reset_sum", {carry, sum}, '0);
        exp_q.delete();
        #10;
        reset_n    = 1'b1;
        last_seen  = '0;
        stall_prev = 1'b0;
        mon_en     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            check("post_reset_idle", out_valid, 1'b0);
        end

        // Traffic resumes normally after reset.
        cycle(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_segment_adder.md
Name: pipelined_segment_adder

Overview:
- Parametrised successor to the fixed 32-bit four-segment ripple adder.
- Splits a WIDTH-bit add into NSEG = WIDTH/SEG_WIDTH segments and registers the carry between segments, so the clock rate is set by one segment.
- Operands are skewed in and results deskewed out; one new operation is accepted per cycle.
- Valid/ready handshake on both sides; used wherever wide sums must meet timing in the datapath.

Parameters:
- WIDTH, 32, operand/sum width in bits.
- SEG_WIDTH, 8, bits per pipeline segment. WIDTH % SEG_WIDTH must be 0, otherwise elaboration is forced to fail.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  operands accepted this cycle when in_valid && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into segment 0.
- out_valid  output  1  sum/carry hold a result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- carry  output  1  bit WIDTH of a + b + cin.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n), clock is clock.
  - Reset state: out_valid=0, sum=0, carry=0, all internal valid bits, skew and carry registers = 0.
  - Reset mid-operation discards all in-flight operations; none emerge after release.
  - in_ready=1 from the first cycle after release.
- Pipeline: NSEG stages. Stage k adds segment k of a and b plus the registered carry from stage k-1 (stage 0 uses cin).
  - Segment k operand bits are delayed k cycles.
  - Segment k result is delayed NSEG-1-k cycles, so all segments of one operation appear together.
- Latency: an operation accepted at edge t shows out_valid=1 after edge t+NSEG (4 cycles at the defaults), when no stall occurs.
- Throughput: 1 operation/cycle. Results are delivered strictly in acceptance order.
- Stall (global): stall = out_valid && !out_ready.
  - While stalled, every pipeline register holds, in_ready=0 combinationally, and sum/carry/out_valid stay stable.
  - When not stalled, in_ready=1.
- Bubbles: if in_valid=0 while in_ready=1, an invalid slot enters the pipeline.
  - When an invalid slot reaches the output, out_valid=0 and sum/carry keep their last delivered value.
- Simultaneous events:
  - out_ready rising in the same cycle as a new in_valid: the output transfer and the input acceptance both occur on that edge.
  - Input accepted during the final stall cycle: it is not accepted, because in_ready=0 in that cycle.
- Arithmetic: unsigned modular. The carry chain is exact across all segments; for example, a full WIDTH-bit ripple of 0xFFFFFFFF + 1 propagates through every stage.
- Degenerate case SEG_WIDTH=WIDTH: NSEG=1, latency 1 cycle, behaviour otherwise identical.

Optional Feature:
- Macro: PIPELINED_SEGMENT_ADDER_ADDSUB_EN.
- Defined:
  - Extra port sub (input, 1), sampled with a and b and carried down the pipeline alongside them.
  - When sub=1, the block computes a + ~b + 1. cin is ignored for that operation. carry = 1 means no borrow (a >= b unsigned).
  - When sub=0, the operation is a + b + cin, as in the base block.
- Not defined: the port is absent and every operation is a + b + cin.

Test Plan:
1. Reset, then a=0x000000FF, b=0x00000001, cin=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000100, carry=0.
2. a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, carry=1 (ripple through all 4 stages).
3. Four back-to-back operations (1+1, 2+2, 0x80000000+0x80000000, 0x7FFFFFFF+1) with out_ready=1 -> results on 4 consecutive cycles, in order: 2 c0, 4 c0, 0 c1, 0x80000000 c0.
4. out_ready held 0 for 3 cycles while out_valid=1 -> in_ready=0, sum/carry stable throughout; after release all queued results are delivered with no loss or duplication.
5. Two operations in flight, reset_n pulsed low asynchronously mid-cycle -> out_valid=0 immediately, and no result appears for 10 cycles after release.
6. With PIPELINED_SEGMENT_ADDER_ADDSUB_EN:
   - sub=1, a=5, b=7 -> sum=0xFFFFFFFE, carry=0.
   - sub=1, a=7, b=5 -> sum=2, carry=1.
   - sub=0, a=5, b=7, cin=1 -> sum=13, carry=0.
